// File: rtl/logit_buffer_if.sv
// Bundle between logit_buffer and its neighbours: the upstream logit stream
// (valid/ready/last) plus the consumer side (start/size/done/busy and the
// combinational read port).
// master: the environment driving the stream and the consumer.
// slave:  the logit_buffer itself.
interface logit_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     in_ready;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     start;
  logic [ADDR_W-1:0]        size;
  logic                     consumer_done;
  logic                     busy;
  logic                     truncated;

  modport master (
    output in_valid, in_data, in_last, rd_addr, consumer_done,
    input  in_ready, rd_data, start, size, busy, truncated
  );

  modport slave (
    input  in_valid, in_data, in_last, rd_addr, consumer_done,
    output in_ready, rd_data, start, size, busy, truncated
  );
endinterface

// File: rtl/logit_buffer.sv
// logit_buffer: collects one frame of signed logits from a valid/ready stream,
// hands it to the argmax consumer with a one-cycle start pulse, serves reads
// combinationally, and stays frozen until the consumer reports done.
// Optional build macro LOGIT_BUF_SENTINEL_EN: out-of-range reads return the
// most negative value instead of zero, so a scan past size never wins.
// resetn is an active-high asynchronous reset despite its name.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FILL  | accepting beats into mem; closes on in_last or on DEPTH beats
// S_ISSUE | start high for one cycle, input stalled
// S_WAIT  | busy high, buffer frozen until consumer_done is sampled
module logit_buffer #(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           resetn,
  logit_buffer_if.slave  bus
);

  localparam int WP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = (WP_W > ADDR_W) ? WP_W : ADDR_W;

`ifdef LOGIT_BUF_SENTINEL_EN
  localparam logic [DATA_W-1:0] OOR_VAL = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] OOR_VAL = '0;
`endif

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                   state;
  logic [WP_W-1:0]          wr_ptr;
  logic [WP_W-1:0]          wr_next;
  logic [WP_W-1:0]          frame_count;
  logic                     start_q;
  logic [ADDR_W-1:0]        size_q;
  logic                     busy_q;
  logic                     trunc_q;
  logic                     accept;
  logic                     close;
  logic signed [DATA_W-1:0] rd_val;

  logic signed [DATA_W-1:0] mem [DEPTH];

  assign bus.in_ready  = (state == S_FILL);
  assign accept        = bus.in_valid && (state == S_FILL);
  assign wr_next       = wr_ptr + WP_W'(1);
  // A frame ends on in_last or when the beat just written fills the last slot.
  assign close         = accept && (bus.in_last || (wr_next == WP_W'(DEPTH)));

  assign bus.start     = start_q;
  assign bus.size      = size_q;
  assign bus.busy      = busy_q;
  assign bus.truncated = trunc_q;
  assign bus.rd_data   = rd_val;

  // Frame sequencing: fill, hand off with a start pulse, wait for done.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= S_FILL;
      wr_ptr      <= '0;
      frame_count <= '0;
      start_q     <= 1'b0;
      size_q      <= '0;
      busy_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (close) begin
            frame_count <= wr_next;
            size_q      <= ADDR_W'(wr_next);
            trunc_q     <= ~bus.in_last;
            wr_ptr      <= '0;
            start_q     <= 1'b1;
            state       <= S_ISSUE;
          end else if (accept) begin
            wr_ptr <= wr_next;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          busy_q  <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.consumer_done) begin
            busy_q <= 1'b0;
            state  <= S_FILL;
          end
        end
        default: begin
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_FILL;
        end
      endcase
    end
  end

  // Logit storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[IDX_W-1:0]] <= bus.in_data;
    end
  end

  // Zero-latency read; the full-width compare keeps large addresses from aliasing.
  always_comb begin
    rd_val = OOR_VAL;
    if (CMP_W'(bus.rd_addr) < CMP_W'(frame_count)) begin
      rd_val = mem[bus.rd_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: doc/logit_buffer.md
Name: logit_buffer

Overview:
- Producer-side partner of the argmax reader. Collects one frame of signed 32-bit logits from an upstream valid/ready stream into an internal register file.
- Pulses `start` and publishes `size` to the argmax engine.
- Serves its `addr` with combinational read data on `rd_addr`/`rd_data`.
- Freezes the buffer until the consumer reports `done`, then reopens for the next frame.

Parameters:
DEPTH, 10, number of logit entries (max frame length), 1..65535
DATA_W, 32, logit width, signed two's complement
ADDR_W, 16, read address / size width

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous reset, active-high (asserted = 1), despite its name
in_valid  input  1  upstream logit beat valid
in_data  input  DATA_W  upstream logit value, signed
in_last  input  1  marks final beat of frame; qualified by in_valid
in_ready  output  1  buffer can accept a beat this cycle
rd_addr  input  ADDR_W  consumer read address
rd_data  output  DATA_W  signed read data for rd_addr, combinational
start  output  1  one-cycle pulse to consumer: frame ready
size  output  ADDR_W  number of valid entries in current frame
consumer_done  input  1  consumer completion level (argmax done)
busy  output  1  frame handed off, consumer working
truncated  output  1  last frame ended by DEPTH limit, not in_last

Behaviour:
- Reset (async, resetn=1):
  - state=FILL, wr_ptr=0, frame_count=0.
  - start=0, size=0, busy=0, truncated=0.
  - Memory contents are not cleared.
- Handshake:
  - A beat is accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = (state==FILL), combinational from state.
  - in_ready does not depend on in_valid.
- FILL state:
  - Each accepted beat writes mem[wr_ptr] <= in_data and increments wr_ptr.
  - A frame closes on an accepted beat with in_last=1, or on the accepted beat that brings wr_ptr to DEPTH, whichever comes first.
  - On close:
    - frame_count <= wr_ptr+1.
    - size <= wr_ptr+1, zero-extended.
    - truncated <= (in_last==0).
    - wr_ptr <= 0.
    - next state ISSUE.
  - A zero-length frame is impossible; in_last is only meaningful with a valid beat.
- ISSUE state:
  - start=1 (registered) for exactly one cycle; in_ready=0.
  - Next state WAIT.
- WAIT state:
  - busy=1, in_ready=0; memory and size held stable.
  - Entered one cycle after start is seen by the consumer, so a stale done from the previous run is already cleared.
  - When consumer_done=1 is sampled: busy <= 0, next state FILL.
  - The first beat of the next frame can be accepted the cycle after return to FILL.
- Output holding:
  - size holds its value from frame close until the next frame close.
  - truncated updates only at frame close.
- Read path:
  - rd_data = mem[rd_addr] when rd_addr < frame_count; otherwise the out-of-range value (see Optional Feature).
  - Purely combinational, zero latency.
  - Valid in all states; contents are guaranteed stable only in ISSUE and WAIT.
- Simultaneous events:
  - consumer_done in FILL or ISSUE is ignored.
  - in_valid outside FILL is stalled; the beat is not consumed.
- Reset mid-operation: returns to FILL and drops the partial frame. A pending start is cancelled (start=0 immediately).
- Width rules:
  - wr_ptr is clog2(DEPTH+1) bits.
  - The rd_addr compare uses the full ADDR_W, with no wrap: rd_addr=DEPTH+5 is out of range, never aliased.

Optional Feature:
- Macro LOGIT_BUF_SENTINEL_EN.
- Defined: out-of-range reads return the most negative value (32'h80000000, i.e. {1'b1,{DATA_W-1{1'b0}}}). A consumer scanning past size can then never select padding.
- Undefined: out-of-range reads return 0.

Test Plan:
- Reset then frame of 3 beats {5,-2,9}, in_last on the 3rd:
  - in_ready=1 throughout; start pulses 1 cycle after the 3rd accept; size=3, truncated=0.
  - rd_addr=2 gives rd_data=9.
  - rd_addr=3 gives rd_data=0, or 0x80000000 with LOGIT_BUF_SENTINEL_EN.
- 12 beats with no in_last, DEPTH=10:
  - Frame closes on the 10th beat: size=10, truncated=1.
  - Beats 11-12 stall with in_ready=0 until consumer_done.
- Argmax attached, frame {1,7,3,7}:
  - Consumer done with max_index=1.
  - busy drops 1 cycle after done; in_ready=1 next cycle.
- consumer_done held at 1 during FILL and in the ISSUE cycle:
  - No state change; frame still hands off.
  - WAIT exits only on done sampled after start.
- Assert resetn mid-FILL after 4 beats, then send 2 beats with last:
  - size=2; start pulses once; no residual start from the aborted frame.
- Back-to-back frames (2 beats, then 3 beats) with done returned immediately:
  - Second start occurs; size=3; rd_data reflects the new values at addr 0..2.
